// File: rtl/gray2bin_rr_sched.sv
// gray2bin_rr_sched: round-robin sharing of one registered Gray-to-binary converter among NREQ requesters
module gray2bin_rr_sched #(
    parameter int SIZE = 8,
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SIZE-1:0]   gray,
    output logic [NREQ-1:0]        gnt,
    output logic [SIZE-1:0]        bin_out,
    output logic [IDW-1:0]         bin_id,
    output logic                   bin_valid,
    input  logic                   bin_ready
);
    localparam logic IDLE = 1'b0;
    localparam logic CONV = 1'b1;

    logic                state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      bin_id_q, bin_id_d;
    logic [SIZE-1:0]     g_q, g_d;
    logic [SIZE-1:0]     bin_q, bin_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                bin_valid_q, bin_valid_d;
    logic [SIZE-1:0]     conv;
    logic [IDW-1:0]      win, idx;
    logic [IDW:0]        sum;
    logic                found;

    // Winner search: first asserted request at or after rr_ptr, wrapping to 0
    always_comb begin
        found = 1'b0;
        win = '0;
        sum = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    // Binary bit i is the XOR of all Gray bits from i upward
    always_comb begin
        conv = '0;
        for (int i = 0; i < SIZE; i++) conv[i] = ^(g_q >> i);
    end

    // Next state: capture a winner in IDLE, push the conversion out in CONV when the output slot frees
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        g_d = g_q;
        id_d = id_q;
        gnt_d = '0;
        bin_d = bin_q;
        bin_id_d = bin_id_q;
        bin_valid_d = bin_valid_q && !bin_ready;
        if (state_q == IDLE) begin
            if (found) begin
                for (int k = 0; k < NREQ; k++) if (win == IDW'(k)) g_d = gray[k*SIZE +: SIZE];
                id_d = win;
                gnt_d = NREQ'(1) << win;
                rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
                state_d = CONV;
            end
        end else if (!bin_valid_q || bin_ready) begin
            bin_d = conv;
            bin_id_d = id_q;
            bin_valid_d = 1'b1;
            state_d = IDLE;
        end
    end

    // State registers with synchronous reset discarding any captured word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            g_q <= '0;
            id_q <= '0;
            gnt_q <= '0;
            bin_q <= '0;
            bin_id_q <= '0;
            bin_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q <= g_d;
            id_q <= id_d;
            gnt_q <= gnt_d;
            bin_q <= bin_d;
            bin_id_q <= bin_id_d;
            bin_valid_q <= bin_valid_d;
        end
    end

    assign gnt = gnt_q;
    assign bin_out = bin_q;
    assign bin_id = bin_id_q;
    assign bin_valid = bin_valid_q;
endmodule

// File: tb/tb_gray2bin_rr_sched.sv
// tb_gray2bin_rr_sched: randomized and directed checks of the shared Gray-to-binary scheduler
module tb_gray2bin_rr_sched;
    localparam int SIZE = 8;
    localparam int NREQ = 4;
    localparam int IDW = 2;
    localparam int MAXW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bin_ready = 1'b1;
    logic bin_valid;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [NREQ*SIZE-1:0] gray = '0;
    logic [SIZE-1:0] bin_out;
    logic [IDW-1:0] bin_id;

    int passed = 0;
    int total = 0;

    logic [SIZE-1:0] wbuf [NREQ][MAXW];
    int wcnt [NREQ];
    int whead [NREQ];
    int head0 [NREQ];
    int gnt_log [$];
    logic [NREQ-1:0] req_log [$];
    int out_id [$];
    logic [SIZE-1:0] out_dat [$];
    int out_cyc [$];
    int exp_w [$];
    logic [SIZE-1:0] exp_d [$];
    int stab_viol;

    always #5 clk = ~clk;

    gray2bin_rr_sched #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .gray(gray), .gnt(gnt),
        .bin_out(bin_out), .bin_id(bin_id), .bin_valid(bin_valid), .bin_ready(bin_ready)
    );

    function automatic logic [SIZE-1:0] g2b(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b = g;
        for (int s = 1; s < SIZE; s++) b ^= g >> s;
        return b;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 0; i < NREQ; i++) if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g == NREQ'(1) << i) return i;
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        gray = '0;
        bin_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic clear_words();
        for (int k = 0; k < NREQ; k++) begin
            wcnt[k] = 0;
            whead[k] = 0;
        end
    endtask

    task automatic add_word(input int k, input logic [SIZE-1:0] w);
        wbuf[k][wcnt[k]] = w;
        wcnt[k]++;
    endtask

    // Requesters present queued words and advance past a word at the edge ending its grant pulse
    task automatic run_engine(input int cycles, input int stall_n, input int pct);
        logic [NREQ-1:0] nreq;
        logic [NREQ*SIZE-1:0] ngray;
        logic pv, pr;
        logic [SIZE-1:0] po;
        logic [IDW-1:0] pi;
        int k;
        gnt_log.delete();
        req_log.delete();
        out_id.delete();
        out_dat.delete();
        out_cyc.delete();
        stab_viol = 0;
        head0 = whead;
        pv = bin_valid;
        po = bin_out;
        pi = bin_id;
        for (int c = 0; c < cycles; c++) begin
            nreq = '0;
            ngray = '0;
            for (int j = 0; j < NREQ; j++) begin
                if (whead[j] < wcnt[j]) begin
                    nreq[j] = 1'b1;
                    ngray[j*SIZE +: SIZE] = wbuf[j][whead[j]];
                end
            end
            req = nreq;
            gray = ngray;
            bin_ready = (c < stall_n) ? 1'b0 : ($urandom_range(99) < pct);
            pr = bin_ready;
            cyc();
            if (pv && pr) begin
                out_id.push_back(int'(pi));
                out_dat.push_back(po);
                out_cyc.push_back(c);
            end else if (pv && (!bin_valid || bin_out !== po || bin_id !== pi)) begin
                stab_viol++;
            end
            if (gnt !== '0) begin
                k = onehot_idx(gnt);
                gnt_log.push_back(k);
                req_log.push_back(nreq);
                if (k >= 0) whead[k]++;
            end
            pv = bin_valid;
            po = bin_out;
            pi = bin_id;
        end
        req = '0;
    endtask

    // Reference: each grant goes to the first requester at or after the pointer; outputs follow grant order
    task automatic build_model(input int ptr0, output int ptr_end);
        int p;
        int w;
        int mi [NREQ];
        p = ptr0;
        mi = head0;
        exp_w.delete();
        exp_d.delete();
        foreach (req_log[j]) begin
            w = pick(req_log[j], p);
            exp_w.push_back(w);
            if (w >= 0) begin
                exp_d.push_back(g2b(wbuf[w][mi[w]]));
                mi[w]++;
                p = (w + 1) % NREQ;
            end else begin
                exp_d.push_back('0);
            end
        end
        ptr_end = p;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        gray = 32'hDEADBEEF;
        bin_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (gnt !== '0) $display("FAIL reset_gnt: got %b expected 0000", gnt); else passed++;
        end
        total++; if (bin_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bin_valid); else passed++;
        total++; if (bin_out !== '0) $display("FAIL reset_out: got %h expected 00", bin_out); else passed++;
        total++; if (bin_id !== '0) $display("FAIL reset_id: got %0d expected 0", bin_id); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        gray[0 +: SIZE] = 8'h80;
        req = 4'b0001;
        cyc();
        req = '0;
        total++; if (gnt !== 4'b0001) $display("FAIL basic_gnt: got %b expected 0001", gnt); else passed++;
        total++; if (bin_valid !== 1'b0) $display("FAIL basic_valid_early: got %b expected 0", bin_valid); else passed++;
        cyc();
        total++; if (gnt !== '0) $display("FAIL basic_gnt_pulse: got %b expected 0000", gnt); else passed++;
        total++; if (bin_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", bin_valid); else passed++;
        total++; if (bin_out !== 8'hFF) $display("FAIL basic_out: got %h expected ff", bin_out); else passed++;
        total++; if (bin_id !== 2'd0) $display("FAIL basic_id: got %0d expected 0", bin_id); else passed++;
        cyc();
        total++; if (bin_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b expected 0", bin_valid); else passed++;
    endtask

    task automatic test_single();
        logic [SIZE-1:0] want [3];
        want[0] = 8'hAA;
        want[1] = 8'h01;
        want[2] = 8'h00;
        do_reset();
        clear_words();
        add_word(2, 8'hFF);
        add_word(2, 8'h01);
        add_word(2, 8'h00);
        run_engine(12, 0, 100);
        total++; if (out_dat.size() != 3) $display("FAIL single_count: got %0d expected 3", out_dat.size()); else passed++;
        for (int j = 0; j < 3 && j < out_dat.size(); j++) begin
            total++; if (out_dat[j] !== want[j]) $display("FAIL single_out%0d: got %h expected %h", j, out_dat[j], want[j]); else passed++;
            total++; if (out_id[j] != 2) $display("FAIL single_id%0d: got %0d expected 2", j, out_id[j]); else passed++;
        end
        for (int j = 1; j < 3 && j < out_cyc.size(); j++) begin
            total++; if (out_cyc[j] - out_cyc[j-1] != 2) $display("FAIL single_rate%0d: got %0d expected 2", j, out_cyc[j] - out_cyc[j-1]); else passed++;
        end
    endtask

    task automatic test_all();
        int order [5];
        int ptr;
        order = '{0, 1, 2, 3, 0};
        do_reset();
        clear_words();
        for (int k = 0; k < NREQ; k++) begin
            add_word(k, SIZE'($urandom_range(255)));
            add_word(k, SIZE'($urandom_range(255)));
        end
        run_engine(24, 0, 100);
        build_model(0, ptr);
        total++; if (gnt_log.size() != 8) $display("FAIL all_grants: got %0d expected 8", gnt_log.size()); else passed++;
        for (int j = 0; j < 5 && j < gnt_log.size(); j++) begin
            total++; if (gnt_log[j] != order[j]) $display("FAIL all_gnt%0d: got %0d expected %0d", j, gnt_log[j], order[j]); else passed++;
        end
        for (int j = 0; j < 5 && j < out_id.size(); j++) begin
            total++; if (out_id[j] != order[j]) $display("FAIL all_id%0d: got %0d expected %0d", j, out_id[j], order[j]); else passed++;
        end
        for (int j = 0; j < out_dat.size() && j < exp_d.size(); j++) begin
            total++; if (out_dat[j] !== exp_d[j]) $display("FAIL all_out%0d: got %h expected %h", j, out_dat[j], exp_d[j]); else passed++;
        end
    endtask

    task automatic test_pair();
        int order [4];
        int ptr;
        order = '{3, 1, 3, 1};
        do_reset();
        clear_words();
        add_word(1, 8'h5A);
        run_engine(8, 0, 100);
        build_model(0, ptr);
        total++; if (gnt_log.size() != 1 || gnt_log[0] != 1) $display("FAIL pair_setup: got %0d grants expected one to 1", gnt_log.size()); else passed++;
        add_word(1, 8'h11);
        add_word(1, 8'h22);
        add_word(3, 8'h33);
        add_word(3, 8'h44);
        run_engine(16, 0, 100);
        build_model(ptr, ptr);
        total++; if (gnt_log.size() != 4) $display("FAIL pair_grants: got %0d expected 4", gnt_log.size()); else passed++;
        for (int j = 0; j < 4 && j < gnt_log.size(); j++) begin
            total++; if (gnt_log[j] != order[j]) $display("FAIL pair_gnt%0d: got %0d expected %0d", j, gnt_log[j], order[j]); else passed++;
        end
        for (int j = 0; j < out_dat.size() && j < exp_d.size(); j++) begin
            total++; if (out_dat[j] !== exp_d[j] || out_id[j] != exp_w[j]) $display("FAIL pair_out%0d: got %0d/%h expected %0d/%h", j, out_id[j], out_dat[j], exp_w[j], exp_d[j]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_words();
        add_word(0, 8'h3C);
        add_word(1, 8'hC3);
        run_engine(14, 6, 100);
        total++; if (gnt_log.size() != 2) $display("FAIL bp_grants: got %0d expected 2", gnt_log.size()); else passed++;
        total++; if (gnt_log.size() > 1 && (gnt_log[0] != 0 || gnt_log[1] != 1)) $display("FAIL bp_order: got %0d,%0d expected 0,1", gnt_log[0], gnt_log[1]); else passed++;
        total++; if (stab_viol != 0) $display("FAIL bp_stable: got %0d changes expected 0", stab_viol); else passed++;
        total++; if (out_id.size() != 2) $display("FAIL bp_count: got %0d expected 2", out_id.size()); else passed++;
        if (out_id.size() == 2) begin
            total++; if (out_id[0] != 0 || out_dat[0] !== g2b(8'h3C)) $display("FAIL bp_first: got %0d/%h expected 0/%h", out_id[0], out_dat[0], g2b(8'h3C)); else passed++;
            total++; if (out_id[1] != 1 || out_dat[1] !== g2b(8'hC3)) $display("FAIL bp_second: got %0d/%h expected 1/%h", out_id[1], out_dat[1], g2b(8'hC3)); else passed++;
            total++; if (out_cyc[0] < 6) $display("FAIL bp_hold: got handshake at %0d expected >= 6", out_cyc[0]); else passed++;
        end
    endtask

    task automatic test_reset_conv();
        do_reset();
        bin_ready = 1'b0;
        gray[0 +: SIZE] = 8'h80;
        gray[SIZE +: SIZE] = 8'h55;
        req = 4'b0011;
        cyc();
        req = 4'b0010;
        cyc();
        cyc();
        total++; if (gnt !== 4'b0010) $display("FAIL rc_gnt1: got %b expected 0010", gnt); else passed++;
        req = '0;
        cyc();
        total++; if (bin_valid !== 1'b1) $display("FAIL rc_stalled: got %b expected 1", bin_valid); else passed++;
        rst = 1'b1;
        cyc();
        total++; if (bin_valid !== 1'b0) $display("FAIL rc_valid: got %b expected 0", bin_valid); else passed++;
        total++; if (gnt !== '0) $display("FAIL rc_gnt: got %b expected 0000", gnt); else passed++;
        total++; if (bin_out !== '0 || bin_id !== '0) $display("FAIL rc_out: got %0d/%h expected 0/00", bin_id, bin_out); else passed++;
        rst = 1'b0;
        bin_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (bin_valid !== 1'b0) $display("FAIL rc_ghost%0d: got %b expected 0", i, bin_valid); else passed++;
        end
        gray[SIZE +: SIZE] = 8'h12;
        gray[2*SIZE +: SIZE] = 8'h34;
        req = 4'b0110;
        cyc();
        total++; if (gnt !== 4'b0010) $display("FAIL rc_ptr: got %b expected 0010", gnt); else passed++;
        req = 4'b0100;
        cyc();
        total++; if (bin_valid !== 1'b1 || bin_id !== 2'd1 || bin_out !== g2b(8'h12)) $display("FAIL rc_after: got %b/%0d/%h expected 1/1/%h", bin_valid, bin_id, bin_out, g2b(8'h12)); else passed++;
        req = '0;
    endtask

    task automatic test_random(input int pct);
        int ptr;
        int n;
        int tot;
        int mw;
        int waited [NREQ];
        do_reset();
        clear_words();
        tot = 0;
        for (int k = 0; k < NREQ; k++) begin
            n = int'($urandom_range(6));
            for (int i = 0; i < n; i++) add_word(k, SIZE'($urandom_range(255)));
            tot += n;
            waited[k] = 0;
        end
        run_engine(300, 0, pct);
        build_model(0, ptr);
        total++; if (gnt_log.size() != tot) $display("FAIL rnd%0d_grants: got %0d expected %0d", pct, gnt_log.size(), tot); else passed++;
        total++; if (out_dat.size() != tot) $display("FAIL rnd%0d_outputs: got %0d expected %0d", pct, out_dat.size(), tot); else passed++;
        total++; if (stab_viol != 0) $display("FAIL rnd%0d_stable: got %0d changes expected 0", pct, stab_viol); else passed++;
        foreach (gnt_log[j]) begin
            total++; if (gnt_log[j] != exp_w[j]) $display("FAIL rnd%0d_gnt%0d: got %0d expected %0d", pct, j, gnt_log[j], exp_w[j]); else passed++;
        end
        for (int j = 0; j < out_dat.size() && j < exp_d.size(); j++) begin
            total++; if (out_id[j] != exp_w[j] || out_dat[j] !== exp_d[j]) $display("FAIL rnd%0d_out%0d: got %0d/%h expected %0d/%h", pct, j, out_id[j], out_dat[j], exp_w[j], exp_d[j]); else passed++;
        end
        mw = 0;
        foreach (gnt_log[j]) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gnt_log[j] == k) waited[k] = 0;
                else if (req_log[j][k]) waited[k]++;
                if (waited[k] > mw) mw = waited[k];
            end
        end
        total++; if (mw >= NREQ) $display("FAIL rnd%0d_starve: got wait %0d expected < %0d", pct, mw, NREQ); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_all();
        test_pair();
        test_backpressure();
        test_reset_conv();
        test_random(100);
        test_random(40);
        test_random(70);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
